// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-arbiter FSM encoding, data-bit count and a
// reference round-robin helper.
//   UART_DBIT        : bits per UART character
//   uart_tx_state_e  : arbiter FSM state encoding (2 bits)
//   rr_next(valid, ptr) : round-robin winner over up to 8 requesters
package uart_pkg;

  localparam int unsigned UART_DBIT = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2
  } uart_tx_state_e;

  // Searches ptr+1, ptr+2, ... wrapping to ptr last. Bits of valid above the
  // real requester count must be zero; then a mod-8 walk visits the live
  // requesters in the same order as a mod-NREQ walk would.
  function automatic logic [2:0] rr_next(input logic [7:0] valid, input logic [2:0] ptr);
    logic [2:0] idx;
    rr_next = ptr;
    for (int i = 8; i >= 1; i--) begin
      idx = ptr + 3'(i);
      if (valid[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/uart_tx_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so that ptr+1
// sits at bit 0, priority-encode the lowest set bit, then unrotate.
//   valid : request vector
//   ptr   : last granted index (lowest priority this round)
//   idx   : winning index (meaningful only when found)
//   found : at least one request set
module uart_tx_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [GW-1:0]   ptr,
  output logic [GW-1:0]   idx,
  output logic            found
);

  logic [NREQ-1:0] rot;
  int unsigned     off;

  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rot[i] = valid[(int'(ptr) + 1 + i) % NREQ];
    end
    off   = 0;
    found = 1'b0;
    // Walk downward so the smallest rotated offset wins.
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = int'(i);
        found = 1'b1;
      end
    end
    idx = GW'((int'(ptr) + 1 + off) % NREQ);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NREQ byte producers.
// A byte is accepted in IDLE (Mealy req_ready), presented on tx_din, started
// with a one-cycle tx_start, and no further grant is made until tx_done_tick.
// Optional macro UART_TX_ARB_LOCK_EN: a byte with req_last=0 locks the grant
// onto its requester until a byte with req_last=1 is accepted.
//   clk, reset_n           : clock, async active-low reset
//   req_valid/data/last    : per-requester byte offer (byte k at [8k+7:8k])
//   req_ready              : one-hot accept strobe
//   tx_start, tx_din       : serializer start pulse and held byte
//   tx_done_tick           : serializer finished the stop bit
//   busy, grant_id         : byte in flight, current/last granted index
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned GW   = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [UART_DBIT*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  output logic                      tx_start,
  output logic [UART_DBIT-1:0]      tx_din,
  input  logic                      tx_done_tick,
  output logic                      busy,
  output logic [GW-1:0]             grant_id
);

  uart_tx_state_e  state;
  logic [NREQ-1:0] eligible;
  logic [GW-1:0]   win;
  logic            found;
  logic            accept;

`ifdef UART_TX_ARB_LOCK_EN
  logic            locked;
  logic [GW-1:0]   lock_id;

  // While locked only the owner may win, even if it is momentarily idle.
  always_comb begin
    eligible = req_valid;
    if (locked) eligible = req_valid & (NREQ'(1) << lock_id);
  end
`else
  logic unused_req_last;
  assign unused_req_last = ^req_last;

  always_comb begin
    eligible = req_valid;
  end
`endif

  uart_tx_rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .valid (eligible),
    .ptr   (grant_id),
    .idx   (win),
    .found (found)
  );

  // reset_n gates the Mealy strobe so nothing is accepted while held in reset.
  assign accept = reset_n && (state == StIdle) && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= StIdle;
      tx_start <= 1'b0;
      tx_din   <= '0;
      busy     <= 1'b0;
      grant_id <= GW'(NREQ - 1);
`ifdef UART_TX_ARB_LOCK_EN
      locked   <= 1'b0;
      lock_id  <= '0;
`endif
    end else begin
      tx_start <= 1'b0;
      unique case (state)
        StIdle: begin
          if (accept) begin
            tx_din   <= req_data[win*UART_DBIT +: UART_DBIT];
            grant_id <= win;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= StStart;
`ifdef UART_TX_ARB_LOCK_EN
            locked   <= ~req_last[win];
            lock_id  <= win;
`endif
          end
        end
        StStart: begin
          state <= StWait;
        end
        StWait: begin
          if (tx_done_tick) begin
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=4).
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned GW   = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0] req_last = '0;
  logic [NREQ-1:0] req_ready;
  logic            tx_start;
  logic [7:0]      tx_din;
  logic            tx_done_tick = 1'b0;
  logic            busy;
  logic [GW-1:0]   grant_id;

  int checks = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .NREQ (NREQ)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Accept one byte in IDLE, check START, wait ~10 cycles, finish with done.
  task automatic run_byte(input string tag, input int exp_id, input logic [7:0] exp_data);
    int extra_start;
    int stray_ready;
    extra_start = 0;
    stray_ready = 0;
    #1;
    check_eq({tag, "_ready"}, 32'(req_ready), 32'(1 << exp_id));
    tick();
    check_eq({tag, "_start"}, 32'(tx_start), 32'(1));
    check_eq({tag, "_gid"}, 32'(grant_id), 32'(exp_id));
    check_eq({tag, "_din"}, 32'(tx_din), 32'(exp_data));
    for (int i = 0; i < 9; i++) begin
      tick();
      if (tx_start) extra_start++;
      if (req_ready != '0 || !busy) stray_ready++;
    end
    check_eq({tag, "_no_double_start"}, 32'(extra_start), 32'(0));
    check_eq({tag, "_hold_wait"}, 32'(stray_ready), 32'(0));
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'(0));
  endtask

  int exp_lock[5];
  int r1_sent;

  initial begin
    // Reset state, with requests pending to prove req_ready is held low.
    req_valid = 4'b1111;
    repeat (3) tick();
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'(0));
    check_eq("rst_start", 32'(tx_start), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_din", 32'(tx_din), 32'(0));
    check_eq("rst_gid", 32'(grant_id), 32'(3));
    req_valid = '0;
    reset_n = 1'b1;
    tick();
    check_eq("idle_busy", 32'(busy), 32'(0));

    // Single request from requester 2.
    req_data = 32'h00A5_0000;
    req_valid = 4'b0100;
    #1;
    check_eq("single_ready", 32'(req_ready), 32'(4'b0100));
    tick();
    req_valid = '0;
    check_eq("single_start", 32'(tx_start), 32'(1));
    check_eq("single_busy", 32'(busy), 32'(1));
    check_eq("single_din", 32'(tx_din), 32'(8'hA5));
    check_eq("single_gid", 32'(grant_id), 32'(2));
    tick();
    check_eq("single_start_off", 32'(tx_start), 32'(0));
    repeat (3) tick();
    check_eq("single_busy_wait", 32'(busy), 32'(1));
    check_eq("single_din_hold", 32'(tx_din), 32'(8'hA5));
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    check_eq("single_busy_done", 32'(busy), 32'(0));

    // Stray done in IDLE: nothing happens.
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    check_eq("stray_idle_busy", 32'(busy), 32'(0));
    check_eq("stray_idle_start", 32'(tx_start), 32'(0));
    // Stray done in START: must still go to WAIT and stay busy.
    req_data = 32'h0000_3C00;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    check_eq("stray_start_pulse", 32'(tx_start), 32'(1));
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    check_eq("stray_start_busy", 32'(busy), 32'(1));
    check_eq("stray_start_no_pulse", 32'(tx_start), 32'(0));
    tick();
    check_eq("stray_start_busy2", 32'(busy), 32'(1));
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    check_eq("stray_done_busy", 32'(busy), 32'(0));

    // Reset in WAIT (requester 3 in flight) returns to IDLE immediately.
    req_data = 32'h1312_1110;
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b1111;
    tick();
    tick();
    check_eq("mid_busy_before", 32'(busy), 32'(1));
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_start", 32'(tx_start), 32'(0));
    check_eq("mid_rst_busy", 32'(busy), 32'(0));
    check_eq("mid_rst_ready", 32'(req_ready), 32'(0));
    check_eq("mid_rst_gid", 32'(grant_id), 32'(3));
    reset_n = 1'b1;

    // Fairness: full tie after reset, requester 0 first.
    for (int g = 0; g < 6; g++) begin
      run_byte($sformatf("fair%0d", g), g % 4, 8'(8'h10 + (g % 4)));
    end

    // Frame lock stimulus: requester 1 alone first, then 0 and 3 join.
`ifdef UART_TX_ARB_LOCK_EN
    exp_lock = '{1, 1, 1, 3, 0};
`else
    exp_lock = '{1, 3, 0, 1, 3};
`endif
    r1_sent = 0;
    req_data = 32'h3000_2110;
    for (int g = 0; g < 5; g++) begin
      if (g == 0) req_valid = 4'b0010;
      else req_valid = (r1_sent < 3) ? 4'b1011 : 4'b1001;
      req_last = (r1_sent == 2) ? 4'b0010 : 4'b0000;
      req_data[15:8] = 8'(8'h21 + r1_sent);
      run_byte($sformatf("lock%0d", g), exp_lock[g],
               (exp_lock[g] == 1) ? 8'(8'h21 + r1_sent) :
               (exp_lock[g] == 3) ? 8'h30 : 8'h10);
      if (exp_lock[g] == 1) r1_sent++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
